// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Shares the divider's enable/stall/flush/done handshake; one product bit per cycle.
module mul_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    output logic         done,
    output logic [N-1:0] result,
    input  logic         high,
    input  logic         src1Signed,
    input  logic         src2Signed,
    input  logic [N-1:0] multiplicand,
    input  logic [N-1:0] multiplier,
    input  logic         enable,
    input  logic         stall,
    input  logic         flush
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_PROCESS = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_high;
    logic              r_negate;
    logic [N-1:0]      r_mcand;
    logic [2*N-1:0]    r_prod;
    logic [CW-1:0]     r_count;

    state_t            w_nextState;
    logic              w_nextHigh;
    logic              w_nextNegate;
    logic [N-1:0]      w_nextMcand;
    logic [2*N-1:0]    w_nextProd;
    logic [CW-1:0]     w_nextCount;

    logic              w_s1;
    logic              w_s2;
    logic [N-1:0]      w_mag1;
    logic [N-1:0]      w_mag2;
    logic              w_zero;
    logic [N:0]        w_addend;
    logic [N:0]        w_sum;
    logic [2*N-1:0]    w_final;
    logic              w_lastCount;

    // Operand magnitudes: the most negative value negates to itself, which read
    // as unsigned is exactly its magnitude, so no extra width is needed.
    assign w_s1   = src1Signed & multiplicand[N-1];
    assign w_s2   = src2Signed & multiplier[N-1];
    assign w_mag1 = w_s1 ? -multiplicand : multiplicand;
    assign w_mag2 = w_s2 ? -multiplier : multiplier;
    assign w_zero = (multiplicand == '0) || (multiplier == '0);

    assign w_addend    = r_prod[0] ? {1'b0, r_mcand} : '0;
    assign w_sum       = {1'b0, r_prod[2*N-1:N]} + w_addend;
    assign w_final     = r_negate ? -r_prod : r_prod;
    assign w_lastCount = (r_count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state  <= S_INIT;
            r_high   <= 1'b0;
            r_negate <= 1'b0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (!stall) begin
            r_state  <= w_nextState;
            r_high   <= w_nextHigh;
            r_negate <= w_nextNegate;
            r_mcand  <= w_nextMcand;
            r_prod   <= w_nextProd;
            r_count  <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextHigh   = r_high;
        w_nextNegate = r_negate;
        w_nextMcand  = r_mcand;
        w_nextProd   = r_prod;
        w_nextCount  = r_count;
        done         = 1'b0;
        result       = '0;

        case (r_state)
            S_INIT: begin
                if (enable) begin
                    w_nextHigh   = high;
                    w_nextNegate = w_s1 ^ w_s2;
                    w_nextMcand  = w_mag1;
                    w_nextCount  = '0;
                    if (w_zero) begin
                        w_nextProd  = '0;
                        w_nextState = S_DONE;
                    end else begin
                        w_nextProd  = {{N{1'b0}}, w_mag2};
                        w_nextState = S_PROCESS;
                    end
                end
            end

            S_PROCESS: begin
                w_nextProd  = {w_sum, r_prod[N-1:1]};
                w_nextCount = r_count + CW'(1);
                if (w_lastCount) begin
                    w_nextState = S_DONE;
                end
            end

            S_DONE: begin
                done         = 1'b1;
                result       = r_high ? w_final[2*N-1:N] : w_final[N-1:0];
                w_nextState  = S_INIT;
                w_nextHigh   = 1'b0;
                w_nextNegate = 1'b0;
                w_nextMcand  = '0;
                w_nextProd   = '0;
                w_nextCount  = '0;
            end

            default: begin
                w_nextState = S_INIT;
            end
        endcase
    end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It is the multiply counterpart of the existing sequential divider.
- It sits beside the divider in the execute stage and uses the same enable/stall/flush/done protocol, so the pipeline drives both units identically.
- It produces one N-bit half of the 2N-bit product, N+1 cycles after accepting operands.

Parameters:
- N, 32, operand/result width in bits; N >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- done  output  1  result valid; high for exactly one non-stalled cycle per operation
- result  output  N  selected product half; driven '0 whenever done=0
- high  input  1  0: return product[N-1:0]; 1: return product[2N-1:N]
- src1Signed  input  1  treat multiplicand as two's complement
- src2Signed  input  1  treat multiplier as two's complement
- multiplicand  input  N  operand 1
- multiplier  input  N  operand 2
- enable  input  1  start request; sampled only in Init
- stall  input  1  freeze all registers
- flush  input  1  abort; same effect as rst
- Signedness per instruction: MUL/MULH = 1/1, MULHSU = 1/0, MULHU = 0/0.

Behaviour:
- Reset/flush (synchronous, rst or flush high at edge):
  - state := Init; all data registers := 0; counter := 0.
  - Outputs: done=0, result=0.
  - rst/flush take priority over stall and enable.
- Stall: when stall=1 and not rst/flush, every register holds, including Done state (done stays high while stalled in Done).
- States: Init, Process, Done (2-bit encoding).
- Init:
  - enable=0: stay in Init.
  - enable=1: latch high, the negate flag and the operand magnitudes.
  - Operands are not sampled again; inputs may change freely afterwards.
- Zero shortcut: if multiplicand==0 or multiplier==0 on accept, go directly to Done with product=0.
- Normal path: go to Process with counter=0.
- Sign handling:
  - s1 = src1Signed & multiplicand[N-1]; s2 = src2Signed & multiplier[N-1].
  - Each magnitude is its N-bit unsigned absolute value when its sign bit is set; -2^(N-1) maps to 2^(N-1).
  - negate = s1 ^ s2.
- Process (one bit per cycle, N cycles):
  - Product register P is 2N bits, initialised {N'0, |multiplier|}.
  - Each cycle: sum = P[2N-1:N] + (P[0] ? |multiplicand| : 0), computed at N+1 bits.
  - Then P := {sum, P[N-1:1]} (shift right by 1), counter++.
  - When counter reaches N-1 and that cycle's update is taken, next state = Done.
- Done:
  - Final product F = negate ? -P : P (2N-bit two's complement).
  - result = high ? F[2N-1:N] : F[N-1:0]; done=1.
  - Next non-stalled cycle returns to Init with registers cleared; enable in Done is ignored.
- Latency: enable accepted at edge T.
  - State is Process during cycles T+1..T+N; done=1 in cycle T+N+1.
  - Zero shortcut: done=1 in cycle T+1.
  - Earliest next accept is the edge after Done (Init, cycle T+N+2).
  - Stall cycles add 1:1 to latency.
- Enable during Process: ignored, no effect on the in-flight operation.
- Reset or flush mid-Process or in Done: the operation is discarded and done never asserts for it.
- Overflow: none; the magnitude product is always < 2^(2N), so no width loss.

Test Plan:
- MUL (1/1, high=0), 7 x 6, enable at T -> done=1 only in cycle T+33; result=42; result=0 in all other cycles.
- MULH / MUL, 0xFFFFFFFF x 0xFFFFFFFF signed -> high=1 gives 0x00000000; high=0 gives 0x00000001.
- MULHU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE. MULHSU (1/0), 0x80000000 x 0xFFFFFFFF -> high=1 gives 0x80000000; high=0 gives 0x80000000.
- Zero shortcut: 0x00000000 x 0x12345678 -> done at T+1, result=0. Same with operands swapped.
- Stall: stall=1 for 5 cycles mid-Process -> done at T+38 with the correct product. Stall=1 while in Done for 3 cycles -> done held high for 4 cycles, result stable.
- Flush at counter=10 -> state Init next cycle and done never asserts. A new enable the following cycle produces a correct result with latency N+1; assert rst mid-operation gives the same outcome.
